// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared constants and types for the parameterised synchronous
//             FIFO: default word width and depth, read-mode encoding, and a
//             helper used by the elaboration-time parameter checks.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 18;
    localparam int FIFO_DEPTH_DEF = 16;

    // Read-mode encoding carried by the FWFT parameter of the top level.
    typedef enum logic {
        RD_MODE_STD  = 1'b0,
        RD_MODE_FWFT = 1'b1
    } rd_mode_e;

    // True for powers of two that are at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram
//  Purpose  : Simple dual-port storage for the FIFO. Synchronous write,
//             asynchronous read addressed by the read pointer. No reset:
//             contents are only ever exposed through valid pointers.
//  Ports    : clk      - write clock
//             i_we     - write enable
//             i_waddr  - write address
//             i_wdata  - write data
//             i_raddr  - read address
//             o_rdata  - read data (combinational from i_raddr)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_sync_fifo
//  Purpose  : Single-clock parameterised FIFO with registered status flags,
//             overflow/underflow pulses and selectable standard or
//             first-word-fall-through read mode.
//  Ports    : clk          - clock, all state on rising edge
//             rst_n        - asynchronous active-low reset
//             din          - write data
//             wr_en        - write request
//             rd_en        - read request
//             dout         - read data
//             full         - occupancy == DEPTH
//             empty        - occupancy == 0
//             almost_full  - occupancy >= AFULL_TH
//             almost_empty - occupancy <= AEMPTY_TH
//             count        - occupancy 0..DEPTH
//             overflow     - pulse: write requested while full
//             underflow    - pulse: read requested while empty
//  Revision : 1.0 - initial release
// ============================================================================
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull_th  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] c_aempty_th = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (WIDTH < 1) begin : g_chk_width
        $error("param_sync_fifo: WIDTH must be >= 1");
    end
    if ((AFULL_TH < 0) || (AFULL_TH > DEPTH)) begin : g_chk_afull
        $error("param_sync_fifo: AFULL_TH outside 0..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH)) begin : g_chk_aempty
        $error("param_sync_fifo: AEMPTY_TH outside 0..DEPTH");
    end
    if ((FWFT != int'(RD_MODE_STD)) && (FWFT != int'(RD_MODE_FWFT))) begin : g_chk_mode
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             full_q,     full_d;
    logic             empty_q,    empty_d;
    logic             afull_q,    afull_d;
    logic             aempty_q,   aempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] dout_q,     dout_d;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_ram_rdata;

    // Acceptance uses the registered flags, so a simultaneous request at
    // a boundary is resolved in favour of whichever side can proceed.
    assign w_wr_acc = wr_en && !full_q;
    assign w_rd_acc = rd_en && !empty_q;

    // ------------------------------------------------------------------
    // Pointer, occupancy and status next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        // Flags are computed from next occupancy and registered, so they
        // appear the cycle after the accepting edge.
        full_d      = (count_d == c_depth);
        empty_d     = (count_d == '0);
        afull_d     = (count_d >= c_afull_th);
        aempty_d    = (count_d <= c_aempty_th);

        overflow_d  = wr_en && full_q;
        underflow_d = rd_en && empty_q;
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (wr_ptr_q[ADDR_W-1:0]),
        .i_wdata (din),
        .i_raddr (rd_ptr_q[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT == int'(RD_MODE_FWFT)) begin : g_rd_fwft
        // Head entry is shown directly while non-empty. The register keeps
        // a copy of the head so dout stays stable at the last head value
        // once the FIFO drains.
        always_comb begin
            dout_d = dout_q;
            if (!empty_q) begin
                dout_d = w_ram_rdata;
            end
        end
        assign dout = empty_q ? dout_q : w_ram_rdata;
    end else begin : g_rd_std
        // Registered output: loads only on an accepted read.
        always_comb begin
            dout_d = dout_q;
            if (w_rd_acc) begin
                dout_d = w_ram_rdata;
            end
        end
        assign dout = dout_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    // The pointer wrap bits are kept for debug visibility only; status is
    // derived from the occupancy counter.
    logic unused_ptr_wrap;
    assign unused_ptr_wrap = wr_ptr_q[ADDR_W] ^ rd_ptr_q[ADDR_W];

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : param_sync_fifo
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_sync_fifo
//  Purpose  : Directed self-checking bench for param_sync_fifo. One standard
//             read-mode instance and one first-word-fall-through instance,
//             both WIDTH=18, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

    localparam int WIDTH = 18;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;

    // Standard-mode instance
    logic [WIDTH-1:0] din0 = '0;
    logic             wr0 = 1'b0;
    logic             rd0 = 1'b0;
    logic [WIDTH-1:0] dout0;
    logic             full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [2:0]       cnt0;

    // FWFT-mode instance
    logic [WIDTH-1:0] din1 = '0;
    logic             wr1 = 1'b0;
    logic             rd1 = 1'b0;
    logic [WIDTH-1:0] dout1;
    logic             full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [2:0]       cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .din(din0), .wr_en(wr0), .rd_en(rd0),
        .dout(dout0), .full(full0), .empty(empty0), .almost_full(afull0),
        .almost_empty(aempty0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    param_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr1), .rd_en(rd1),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(afull1),
        .almost_empty(aempty1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- power-on reset ----------------
        tick();
        tick();
        check("rst_empty",  32'(empty0), 32'd1);
        check("rst_full",   32'(full0),  32'd0);
        check("rst_count",  32'(cnt0),   32'd0);
        check("rst_aempty", 32'(aempty0), 32'd1);
        check("rst_afull",  32'(afull0), 32'd0);
        check("rst_dout",   32'(dout0),  32'h0);
        rst_n = 1'b1;

        // ---------------- fill ----------------
        for (int i = 1; i <= 4; i++) begin
            din0 = WIDTH'(i);
            wr0  = 1'b1;
            tick();
            check($sformatf("fill_count%0d", i), 32'(cnt0),   32'(i));
            check($sformatf("fill_afull%0d", i), 32'(afull0), (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("fill_full%0d", i),  32'(full0),  (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("fill_empty%0d", i), 32'(empty0), 32'd0);
        end
        din0 = 18'h5;
        tick();
        check("ovf_pulse", 32'(ovf0), 32'd1);
        check("ovf_count", 32'(cnt0), 32'd4);
        wr0 = 1'b0;
        tick();
        check("ovf_clear", 32'(ovf0), 32'd0);

        // ---------------- drain ----------------
        for (int i = 1; i <= 4; i++) begin
            rd0 = 1'b1;
            tick();
            check($sformatf("drain_dout%0d", i),   32'(dout0),   32'(i));
            check($sformatf("drain_count%0d", i),  32'(cnt0),    32'(4 - i));
            check($sformatf("drain_empty%0d", i),  32'(empty0),  (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("drain_aempty%0d", i), 32'(aempty0), (i >= 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("unf_pulse", 32'(unf0),  32'd1);
        check("unf_dout",  32'(dout0), 32'h4);
        rd0 = 1'b0;
        tick();
        check("unf_clear", 32'(unf0),  32'd0);
        check("hold_dout", 32'(dout0), 32'h4);

        // ---------------- wrap-around ----------------
        for (int k = 0; k < 10; k++) begin
            din0 = WIDTH'(32'h10 + k);
            wr0  = 1'b1;
            tick();
            wr0 = 1'b0;
            check($sformatf("wrap_cnt_w%0d", k), 32'(cnt0), 32'd1);
            rd0 = 1'b1;
            tick();
            rd0 = 1'b0;
            check($sformatf("wrap_dout%0d", k),  32'(dout0), 32'h10 + 32'(k));
            check($sformatf("wrap_cnt_r%0d", k), 32'(cnt0), 32'd0);
        end

        // ---------------- simultaneous at full ----------------
        for (int i = 0; i < 4; i++) begin
            din0 = WIDTH'(32'h20 + i);
            wr0  = 1'b1;
            tick();
        end
        check("sim_full_pre", 32'(full0), 32'd1);
        din0 = 18'h24;
        rd0  = 1'b1;
        tick();
        wr0 = 1'b0;
        rd0 = 1'b0;
        check("sim_full_count", 32'(cnt0),  32'd3);
        check("sim_full_ovf",   32'(ovf0),  32'd1);
        check("sim_full_dout",  32'(dout0), 32'h20);
        check("sim_full_flag",  32'(full0), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            rd0 = 1'b1;
            tick();
            check($sformatf("sim_full_drain%0d", i), 32'(dout0), 32'h20 + 32'(i));
        end
        rd0 = 1'b0;
        check("sim_full_empty", 32'(empty0), 32'd1);

        // ---------------- simultaneous at empty ----------------
        din0 = 18'h2A;
        wr0  = 1'b1;
        rd0  = 1'b1;
        tick();
        wr0 = 1'b0;
        rd0 = 1'b0;
        check("sim_empty_count", 32'(cnt0),  32'd1);
        check("sim_empty_unf",   32'(unf0),  32'd1);
        check("sim_empty_dout",  32'(dout0), 32'h23);
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        check("sim_empty_read", 32'(dout0), 32'h2A);
        check("sim_empty_cnt0", 32'(cnt0),  32'd0);

        // ---------------- FWFT mode ----------------
        check("fwft_rst_empty", 32'(empty1), 32'd1);
        check("fwft_rst_dout",  32'(dout1),  32'h0);
        din1 = 18'h3FFFF;
        wr1  = 1'b1;
        tick();
        check("fwft_empty_fall", 32'(empty1), 32'd0);
        check("fwft_head",       32'(dout1),  32'h3FFFF);
        din1 = 18'h155;
        tick();
        din1 = 18'h2AA;
        tick();
        wr1 = 1'b0;
        check("fwft_head_hold", 32'(dout1), 32'h3FFFF);
        check("fwft_count3",    32'(cnt1),  32'd3);
        rd1 = 1'b1;
        tick();
        check("fwft_next1", 32'(dout1), 32'h155);
        tick();
        check("fwft_next2", 32'(dout1), 32'h2AA);
        tick();
        rd1 = 1'b0;
        check("fwft_drained", 32'(empty1), 32'd1);
        check("fwft_stable",  32'(dout1),  32'h2AA);

        // ---------------- reset mid-operation ----------------
        din0 = 18'h7;
        wr0  = 1'b1;
        tick();
        din0 = 18'h8;
        tick();
        wr0 = 1'b0;
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        check("mid_pre_dout",  32'(dout0), 32'h7);
        check("mid_pre_count", 32'(cnt0),  32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty0), 32'd1);
        check("mid_rst_full",  32'(full0),  32'd0);
        check("mid_rst_count", 32'(cnt0),   32'd0);
        check("mid_rst_dout",  32'(dout0),  32'h0);
        tick();
        rst_n = 1'b1;
        rd0 = 1'b1;
        tick();
        rd0 = 1'b0;
        check("post_rst_unf",  32'(unf0),  32'd1);
        check("post_rst_dout", 32'(dout0), 32'h0);
        check("post_rst_cnt",  32'(cnt0),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_sync_fifo
`default_nettype wire
